// File: rtl/decode_pkg.sv
// Shared RV32I decode types: opcode/funct constants, ALU operator and select enums,
// and the packed decoded bundle carried through the decode stage registers.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_IMM  = 2'd2,
        OP1_ZERO = 2'd3
    } op1_src_e;

    typedef enum logic [2:0] {
        OP2_RS2  = 3'd0,
        OP2_IMM  = 3'd1,
        OP2_ZERO = 3'd2,
        OP2_FOUR = 3'd3
    } op2_src_e;

    typedef enum logic [1:0] {
        PC_OP1_PC  = 2'd0,
        PC_OP1_RS1 = 2'd1
    } pc_src_e;

    // Conditional branches resolve on the ALU result (SUB/SLT/SLTU) being zero or not.
    typedef enum logic [1:0] {
        ALWAYS_NOT_BRANCH = 2'd0,
        ALWAYS_BRANCH     = 2'd1,
        BRANCH_IF_ZERO    = 2'd2,
        BRANCH_IF_NONZERO = 2'd3
    } next_pc_e;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_RAM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu_op;
        op1_src_e    op1_src;
        op2_src_e    op2_src;
        pc_src_e     pc_op1_src;
        next_pc_e    next_pc_src;
        wb_src_e     wb_src;
        logic [2:0]  mem_funct3;
        logic        reg_wren;
        logic        ram_wren;
        logic        illegal;
    } bundle_t;

    localparam int BUNDLE_W = $bits(bundle_t);

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I instruction -> decoded bundle; RV32M operators when DECODE_RV32M_EN is defined.
// Zero latency; no flow control of its own.
module decode_logic
    import decode_pkg::*;
(
    input  logic [31:0]         inst,
    output logic [BUNDLE_W-1:0] dec_dat
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    bundle_t  d;
    logic     legal;
    logic     wr;
    logic     ram;
    next_pc_e br;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        d             = '0;
        legal         = 1'b1;
        wr            = 1'b0;
        ram           = 1'b0;
        br            = ALWAYS_NOT_BRANCH;
        d.rs1         = inst[19:15];
        d.rs2         = inst[24:20];
        d.rd          = inst[11:7];
        d.mem_funct3  = funct3;
        d.alu_op      = ALU_ADD;
        d.op1_src     = OP1_RS1;
        d.op2_src     = OP2_RS2;
        d.pc_op1_src  = PC_OP1_PC;
        d.wb_src      = WB_ALU;

        case (opcode)
            OPC_LUI: begin
                d.imm     = imm_u;
                d.op1_src = OP1_IMM;
                d.op2_src = OP2_ZERO;
                wr        = 1'b1;
            end
            OPC_AUIPC: begin
                d.imm     = imm_u;
                d.op1_src = OP1_PC;
                d.op2_src = OP2_IMM;
                wr        = 1'b1;
            end
            // Jumps: the ALU forms the link value PC+4, the PC adder forms the target.
            OPC_JAL: begin
                d.imm     = imm_j;
                d.op1_src = OP1_PC;
                d.op2_src = OP2_FOUR;
                br        = ALWAYS_BRANCH;
                wr        = 1'b1;
            end
            OPC_JALR: begin
                d.imm        = imm_i;
                d.op1_src    = OP1_PC;
                d.op2_src    = OP2_FOUR;
                d.pc_op1_src = PC_OP1_RS1;
                br           = ALWAYS_BRANCH;
                wr           = 1'b1;
                legal        = (funct3 == F3_JALR);
            end
            OPC_BRANCH: begin
                d.imm = imm_b;
                case (funct3)
                    F3_BEQ:  begin d.alu_op = ALU_SUB;  br = BRANCH_IF_ZERO;    end
                    F3_BNE:  begin d.alu_op = ALU_SUB;  br = BRANCH_IF_NONZERO; end
                    F3_BLT:  begin d.alu_op = ALU_SLT;  br = BRANCH_IF_NONZERO; end
                    F3_BGE:  begin d.alu_op = ALU_SLT;  br = BRANCH_IF_ZERO;    end
                    F3_BLTU: begin d.alu_op = ALU_SLTU; br = BRANCH_IF_NONZERO; end
                    F3_BGEU: begin d.alu_op = ALU_SLTU; br = BRANCH_IF_ZERO;    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                d.imm     = imm_i;
                d.op2_src = OP2_IMM;
                d.wb_src  = WB_RAM;
                wr        = 1'b1;
                legal     = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OPC_STORE: begin
                d.imm     = imm_s;
                d.op2_src = OP2_IMM;
                ram       = 1'b1;
                legal     = (funct3 < 3'b011);
            end
            OPC_OP_IMM: begin
                d.imm     = imm_i;
                d.op2_src = OP2_IMM;
                wr        = 1'b1;
                case (funct3)
                    F3_ADD_SUB: d.alu_op = ALU_ADD;
                    F3_SLT:     d.alu_op = ALU_SLT;
                    F3_SLTU:    d.alu_op = ALU_SLTU;
                    F3_XOR:     d.alu_op = ALU_XOR;
                    F3_OR:      d.alu_op = ALU_OR;
                    F3_AND:     d.alu_op = ALU_AND;
                    F3_SLL: begin
                        d.alu_op = ALU_SLL;
                        legal    = (funct7 == F7_BASE);
                    end
                    default: begin
                        if (funct7 == F7_BASE)     d.alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) d.alu_op = ALU_SRA;
                        else                       legal    = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                wr = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD_SUB: d.alu_op = ALU_ADD;
                        F3_SLL:     d.alu_op = ALU_SLL;
                        F3_SLT:     d.alu_op = ALU_SLT;
                        F3_SLTU:    d.alu_op = ALU_SLTU;
                        F3_XOR:     d.alu_op = ALU_XOR;
                        F3_SRL_SRA: d.alu_op = ALU_SRL;
                        F3_OR:      d.alu_op = ALU_OR;
                        default:    d.alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    d.alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
                    d.alu_op = ALU_SRA;
`ifdef DECODE_RV32M_EN
                end else if (funct7 == F7_MULDIV) begin
                    d.alu_op = alu_op_e'(5'(ALU_MUL) + {2'b00, funct3});
`endif
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        // Illegal words still flow so execute can trap, but must not change state.
        d.illegal     = !legal;
        d.reg_wren    = wr && legal && (inst[11:7] != 5'd0);
        d.ram_wren    = ram && legal;
        d.next_pc_src = legal ? br : ALWAYS_NOT_BRANCH;
    end

    assign dec_dat = d;

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with output register plus one skid entry; DECODE_RV32M_EN adds RV32M.
// Latency 1 cycle from in_valid&in_ready to out_valid; flush drops held and incoming instructions.
// Backpressure: in_ready = !skid_full (registered, no combinational path from out_ready).
module decode_stage
    import decode_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int XLEN     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instruction,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [4:0]          rs1_address,
    output logic [4:0]          rs2_address,
    output logic [4:0]          rd_address,
    output logic [XLEN-1:0]     imm,
    output logic [4:0]          alu_rd_operator,
    output logic [1:0]          alu_rd_operand1_src,
    output logic [2:0]          alu_rd_operand2_src,
    output logic [1:0]          alu_pc_operand1_src,
    output logic [1:0]          next_pc_src,
    output logic                reg_write_data_src,
    output logic [2:0]          mem_funct3,
    output logic                reg_wren,
    output logic                ram_wren,
    output logic                illegal
);

    generate
        if (XLEN != 32) begin : g_xlen_check
            $error("decode_stage supports XLEN = 32 only");
        end
    endgenerate

    logic [BUNDLE_W-1:0] dec_dat;
    bundle_t             dec_bundle;
    bundle_t             out_q;
    bundle_t             skid_q;
    logic [PC_WIDTH-1:0] out_pc_q;
    logic [PC_WIDTH-1:0] skid_pc_q;
    logic                out_vld_q;
    logic                skid_vld_q;
    logic                accept;
    logic                advance;

    decode_logic u_decode_logic (
        .inst    (in_instruction),
        .dec_dat (dec_dat)
    );

    assign dec_bundle = bundle_t'(dec_dat);
    assign in_ready   = !skid_vld_q;
    assign accept     = in_valid && in_ready;
    assign advance    = !out_vld_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
            out_pc_q   <= '0;
            skid_pc_q  <= '0;
        end else if (flush) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (advance) begin
            // The skid entry is older than anything arriving now, so it drains first.
            if (skid_vld_q) begin
                out_q      <= skid_q;
                out_pc_q   <= skid_pc_q;
                out_vld_q  <= 1'b1;
                skid_vld_q <= accept;
                if (accept) begin
                    skid_q    <= dec_bundle;
                    skid_pc_q <= in_pc;
                end
            end else begin
                out_vld_q <= accept;
                if (accept) begin
                    out_q    <= dec_bundle;
                    out_pc_q <= in_pc;
                end
            end
        end else if (accept) begin
            skid_q     <= dec_bundle;
            skid_pc_q  <= in_pc;
            skid_vld_q <= 1'b1;
        end
    end

    assign out_valid           = out_vld_q;
    assign out_pc              = out_pc_q;
    assign rs1_address         = out_q.rs1;
    assign rs2_address         = out_q.rs2;
    assign rd_address          = out_q.rd;
    assign imm                 = out_q.imm;
    assign alu_rd_operator     = out_q.alu_op;
    assign alu_rd_operand1_src = out_q.op1_src;
    assign alu_rd_operand2_src = out_q.op2_src;
    assign alu_pc_operand1_src = out_q.pc_op1_src;
    assign next_pc_src         = out_q.next_pc_src;
    assign reg_write_data_src  = out_q.wb_src;
    assign mem_funct3          = out_q.mem_funct3;
    assign reg_wren            = out_q.reg_wren;
    assign ram_wren            = out_q.ram_wren;
    assign illegal             = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// against a queue-based reference model of the two-deep decode pipeline.
module tb_decode_stage;

    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   in_instruction = '0;
    logic [PW-1:0] in_pc = '0;
    logic          in_ready, out_valid;
    logic [PW-1:0] out_pc;
    logic [4:0]    rs1_address, rs2_address, rd_address, alu_rd_operator;
    logic [31:0]   imm;
    logic [1:0]    alu_rd_operand1_src, alu_pc_operand1_src, next_pc_src;
    logic [2:0]    alu_rd_operand2_src, mem_funct3;
    logic          reg_write_data_src, reg_wren, ram_wren, illegal;

    always #5 clk = ~clk;

    decode_stage #(.PC_WIDTH(PW), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1_address(rs1_address), .rs2_address(rs2_address), .rd_address(rd_address),
        .imm(imm), .alu_rd_operator(alu_rd_operator),
        .alu_rd_operand1_src(alu_rd_operand1_src), .alu_rd_operand2_src(alu_rd_operand2_src),
        .alu_pc_operand1_src(alu_pc_operand1_src), .next_pc_src(next_pc_src),
        .reg_write_data_src(reg_write_data_src), .mem_funct3(mem_funct3),
        .reg_wren(reg_wren), .ram_wren(ram_wren), .illegal(illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [4:0]  op;
        logic [1:0]  op1;
        logic [2:0]  op2;
        logic [1:0]  pcop1;
        logic [1:0]  npc;
        logic        wb;
        logic [2:0]  f3;
        logic        regw, ramw, ill;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_out = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    function automatic logic [31:0] ref_imm(input logic [31:0] w, input int fmt);
        int v;
        case (fmt)
            0: begin v = int'(w[31:20]); if (w[31]) v -= 4096; end
            1: begin v = int'({w[31:25], w[11:7]}); if (w[31]) v -= 4096; end
            2: begin v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2; if (w[31]) v -= 4096; end
            3: begin v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2; if (w[31]) v -= 1048576; end
            default: v = int'(w & 32'hFFFF_F000);
        endcase
        return 32'(v);
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ok, wr, mw;
        int alu_tab[8];
        int br_op[8];
        int br_pol[8];
        alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
        br_op   = '{1, 1, 0, 0, 3, 3, 4, 4};
        br_pol  = '{2, 3, 0, 0, 3, 2, 3, 2};
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        e.pc = pc; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.f3 = f3;
        ok = 1; wr = 0; mw = 0;
        case (w[6:0])
            7'h37: begin e.imm = ref_imm(w, 4); e.op1 = 2; e.op2 = 2; wr = 1; end
            7'h17: begin e.imm = ref_imm(w, 4); e.op1 = 1; e.op2 = 1; wr = 1; end
            7'h6F: begin e.imm = ref_imm(w, 3); e.op1 = 1; e.op2 = 3; e.npc = 1; wr = 1; end
            7'h67: begin e.imm = ref_imm(w, 0); e.op1 = 1; e.op2 = 3; e.pcop1 = 1; e.npc = 1; wr = 1; ok = (f3 == 0); end
            7'h63: begin
                e.imm = ref_imm(w, 2); ok = !(f3 inside {3'd2, 3'd3});
                e.op = 5'(br_op[f3]); e.npc = 2'(br_pol[f3]);
            end
            7'h03: begin e.imm = ref_imm(w, 0); e.op2 = 1; e.wb = 1; wr = 1; ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; end
            7'h23: begin e.imm = ref_imm(w, 1); e.op2 = 1; mw = 1; ok = (f3 < 3); end
            7'h13: begin
                e.imm = ref_imm(w, 0); e.op2 = 1; wr = 1; e.op = 5'(alu_tab[f3]);
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin
                    if (f7 == 7'h20) e.op = 7; else ok = (f7 == 0);
                end
            end
            7'h33: begin
                wr = 1;
                if (f7 == 0) e.op = 5'(alu_tab[f3]);
                else if (f7 == 7'h20 && f3 == 0) e.op = 1;
                else if (f7 == 7'h20 && f3 == 5) e.op = 7;
                else if (f7 == 7'h01) begin
`ifdef DECODE_RV32M_EN
                    e.op = 5'(10 + int'(f3));
`else
                    ok = 0;
`endif
                end else ok = 0;
            end
            default: ok = 0;
        endcase
        e.ill  = !ok;
        e.regw = wr && ok && (w[11:7] != 0);
        e.ramw = mw && ok;
        if (!ok) e.npc = 0;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.pc = out_pc; o.rs1 = rs1_address; o.rs2 = rs2_address; o.rd = rd_address;
        o.imm = imm; o.op = alu_rd_operator; o.op1 = alu_rd_operand1_src;
        o.op2 = alu_rd_operand2_src; o.pcop1 = alu_pc_operand1_src; o.npc = next_pc_src;
        o.wb = reg_write_data_src; o.f3 = mem_funct3; o.regw = reg_wren;
        o.ramw = ram_wren; o.ill = illegal;
        return o;
    endfunction

    // ALU/select fields of an illegal word carry no meaning; only the safety fields matter.
    function automatic exp_t view(input exp_t o, input exp_t e);
        exp_t v;
        v = o;
        if (e.ill) begin v.op = e.op; v.op1 = e.op1; v.op2 = e.op2; v.pcop1 = e.pcop1; v.wb = e.wb; end
        return v;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        logic [6:0]  opcs[9];
        int k;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 9) w[6:0] = opcs[k];
        else if (k == 9) w[6:0] = 7'h33;
        if (w[6:0] == 7'h13 || w[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    // Drive one cycle and advance the model: two held entries at most, flush/reset empty it.
    task automatic tick(input logic iv, input logic [31:0] w, input logic ordy, input logic fl);
        bit acc;
        acc = iv && (q.size() < 2);
        in_valid = iv; in_instruction = w; in_pc = pc_ctr; out_ready = ordy; flush = fl;
        if (rst || fl) q.delete();
        else begin
            if (q.size() > 0 && ordy) begin void'(q.pop_front()); n_out++; end
            if (acc) q.push_back(ref_decode(w, pc_ctr));
        end
        pc_ctr += 4;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (observed() !== '0) begin n_fail++; $display("FAIL reset_bundle: got %h want 0", observed()); end
    endtask

    task automatic test_addi();
        tick(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        n_checks++; if (imm !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addi_imm: got %h want ffffffff", imm); end
        n_checks++; if (alu_rd_operator !== 5'd0) begin n_fail++; $display("FAIL addi_op: got %0d want 0", alu_rd_operator); end
        n_checks++; if (reg_wren !== 1'b1 || illegal !== 1'b0) begin n_fail++; $display("FAIL addi_wren_ill: got %b%b want 10", reg_wren, illegal); end
        n_checks++; if (q.size() == 0 || view(observed(), q[0]) !== q[0]) begin n_fail++; $display("FAIL addi_bundle: got %h want %h", observed(), q[0]); end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ws[4];
        int idx, start_out;
        bit acc;
        ws = '{32'h00500113, 32'h40208233, 32'h0040A283, 32'h00112423};
        idx = 0;
        start_out = n_out;
        for (int c = 0; c < 16; c++) begin
            acc = (idx < 4) && (q.size() < 2);
            tick(idx < 4, ws[idx % 4], (c == 0) || (c >= 6), 1'b0);
            if (acc) idx++;
            if (acc && idx == 2) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_drop: got %b want 0", in_ready); end
            end
            n_checks++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL bp_valid c=%0d: got %b want %b", c, out_valid, q.size() > 0); end
            if (q.size() > 0) begin
                n_checks++; if (view(observed(), q[0]) !== q[0]) begin n_fail++; $display("FAIL bp_bundle c=%0d: got %h want %h", c, observed(), q[0]); end
            end
        end
        n_checks++; if (n_out - start_out != 4 || idx != 4) begin n_fail++; $display("FAIL bp_count: got %0d out/%0d in want 4/4", n_out - start_out, idx); end
    endtask

    task automatic test_flush();
        tick(1'b1, 32'h00100093, 1'b0, 1'b0);
        tick(1'b1, 32'h00200113, 1'b0, 1'b0);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full: got in_ready %b want 0", in_ready); end
        tick(1'b1, 32'h00300193, 1'b0, 1'b1);
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full_clear: got vld %b rdy %b want 0 1", out_valid, in_ready); end
        tick(1'b1, 32'h00400213, 1'b1, 1'b0);
        tick(1'b1, 32'h00500293, 1'b0, 1'b1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %b want 0", out_valid); end
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b0);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost c=%0d: got %b want 0", c, out_valid); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ws[2];
        ws = '{32'h00000000, 32'h00002063};
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, ws[i], 1'b1, 1'b0);
            n_checks++; if (out_valid !== 1'b1 || illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_%0d: got vld %b ill %b want 1 1", i, out_valid, illegal); end
            n_checks++; if (reg_wren !== 1'b0 || ram_wren !== 1'b0 || next_pc_src !== 2'd0) begin n_fail++; $display("FAIL illegal_safe_%0d: got %b %b %0d want 0 0 0", i, reg_wren, ram_wren, next_pc_src); end
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_misc();
        tick(1'b1, 32'h00208033, 1'b1, 1'b0);
        n_checks++; if (reg_wren !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL add_x0: got wren %b ill %b want 0 0", reg_wren, illegal); end
        tick(1'b1, 32'hFE209CE3, 1'b1, 1'b0);
        n_checks++; if (imm !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL bne_imm: got %h want fffffff8", imm); end
        n_checks++; if (next_pc_src !== 2'd3 || alu_rd_operator !== 5'd1) begin n_fail++; $display("FAIL bne_ctl: got npc %0d op %0d want 3 1", next_pc_src, alu_rd_operator); end
        tick(1'b1, 32'h022081B3, 1'b1, 1'b0);
`ifdef DECODE_RV32M_EN
        n_checks++; if (alu_rd_operator !== 5'd10 || illegal !== 1'b0 || reg_wren !== 1'b1) begin n_fail++; $display("FAIL mul: got op %0d ill %b wren %b want 10 0 1", alu_rd_operator, illegal, reg_wren); end
`else
        n_checks++; if (illegal !== 1'b1 || reg_wren !== 1'b0) begin n_fail++; $display("FAIL mul_illegal: got ill %b wren %b want 1 0", illegal, reg_wren); end
`endif
        tick(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midflight();
        tick(1'b1, 32'h00A00513, 1'b0, 1'b0);
        tick(1'b1, 32'h00B00593, 1'b0, 1'b0);
        rst = 1'b1;
        tick(1'b1, 32'h00C00613, 1'b0, 1'b1);
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_hs: got vld %b rdy %b want 0 1", out_valid, in_ready); end
        n_checks++; if (observed() !== '0) begin n_fail++; $display("FAIL midreset_bundle: got %h want 0", observed()); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            tick($urandom_range(0, 3) != 0, gen_inst(), $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
            n_checks++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, out_valid, q.size() > 0); end
            n_checks++; if (in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                n_checks++; if (view(observed(), q[0]) !== q[0]) begin n_fail++; $display("FAIL rnd_bundle c=%0d: got %h want %h", c, observed(), q[0]); end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_addi();
        test_backpressure();
        test_flush();
        test_illegal();
        test_misc();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked RV32I instruction-decode stage. Sits between the fetch stage and the execute/ALU stage of the pipelined core.
- Successor to the combinational decoder:
  - Fully sign-extended immediates.
  - Illegal-instruction detection.
  - Load/store width passthrough.
  - Valid/ready flow control with a 2-entry skid buffer.
  - Pipeline flush.
  - Parametrised PC width.

Parameters:
- PC_WIDTH, 32, width of the PC carried alongside the instruction.
- XLEN, 32, immediate/output data width; only 32 is supported (any other value is a compile-time error).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held and incoming instructions this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept.
- in_instruction  in  32  raw instruction word.
- in_pc  in  PC_WIDTH  PC of the instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  PC_WIDTH  registered PC.
- rs1_address, rs2_address, rd_address  out  5 each  register indices.
- imm  out  XLEN  sign-extended immediate.
- alu_rd_operator  out  5  ALU operation (package enum).
- alu_rd_operand1_src  out  2  ALU operand 1 select.
- alu_rd_operand2_src  out  3  ALU operand 2 select.
- alu_pc_operand1_src  out  2  PC-adder operand select.
- next_pc_src  out  2  branch policy.
- reg_write_data_src  out  1  ALU or RAM writeback.
- mem_funct3  out  3  load/store width and signedness (funct3 passthrough).
- reg_wren  out  1  register write enable.
- ram_wren  out  1  RAM write enable.
- illegal  out  1  undecodable instruction.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0; skid entry empty.
  - All bundle outputs 0, next_pc_src=ALWAYS_NOT_BRANCH.
  - in_ready=1 from the first cycle after reset.
- Decode is combinational on in_instruction; the bundle is registered.
- Latency: 1 cycle from an accepted input (in_valid & in_ready) to out_valid.
- in_ready = !skid_full. in_ready is a registered signal and does not depend combinationally on out_ready.
- Output register advances when !out_valid | out_ready.
  - If the output register is stalled while an input is accepted, the decoded bundle goes to the skid entry.
  - The skid entry drains into the output register first; order is strictly preserved.
- Simultaneous accept-in and drain-out with the skid entry occupied: skid→output, new input→skid; no bubble.
- flush=1: out_valid←0, skid←empty, and the incoming instruction that cycle is dropped even if the handshake fires. flush has priority over accept; rst has priority over flush.
- Immediates:
  - I: sign(inst[31]) ∥ inst[31:20].
  - S: sign ∥ inst[31:25] ∥ inst[11:7].
  - B: sign ∥ inst[7] ∥ inst[30:25] ∥ inst[11:8] ∥ 0.
  - U: inst[31:12] ∥ 12'b0.
  - J: sign ∥ inst[19:12] ∥ inst[20] ∥ inst[30:21] ∥ 0.
  - R-type: imm=0.
- LUI: operand1=IMM, operand2=ZERO, op=ADD (imm is already shifted).
- AUIPC: operand1=PC, operand2=IMM, op=ADD.
- Branch/JAL/JALR/load/store control encoding unchanged from the current core.
- JALR: alu_pc_operand1_src=RS1.
- illegal=1 for any of:
  - Unknown opcode.
  - inst[1:0]≠2'b11.
  - Unlisted funct7 on OP or shift-immediate.
  - Branch funct3 010/011.
  - Load funct3 011/110/111.
  - Store funct3 ≥011.
  - JALR funct3≠000.
- When illegal=1: reg_wren=0, ram_wren=0, next_pc_src=ALWAYS_NOT_BRANCH; the bundle still flows so a trap can be raised downstream.
- rd_address==0 forces reg_wren=0.
- Held outputs are stable while out_valid & !out_ready.

Optional Feature:
- Macro: DECODE_RV32M_EN.
  - Defined: OP opcode with funct7=0000001 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU to package operators 10–17, with reg_wren=1 (subject to the rd=x0 rule).
  - Undefined: these encodings raise illegal=1.
- Operator width stays 5 bits in both builds.

Decomposition:
- Shared package decode_pkg:
  - Opcode, funct3 and funct7 constants.
  - ALU operator enum (5-bit).
  - Operand-select, next_pc_src and writeback-select enums.
  - A packed decoded-bundle struct.
- One sub-module, decode_logic: pure combinational instruction→bundle.
- decode_stage owns the output register, skid register and handshake.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093) → 1 cycle later out_valid=1, imm=0xFFFFFFFF, op=ADD, reg_wren=1, illegal=0.
- Stream 4 instructions with out_ready held 0 from cycle 2 → in_ready drops after the 2nd accept; release out_ready → all 4 emerge in order, none lost or duplicated.
- flush asserted together with in_valid while both registers are full → next cycle out_valid=0, in_ready=1, and the dropped instruction never appears.
- 0x00000000 and BEQ with funct3=010 → illegal=1, reg_wren=0, ram_wren=0, next_pc_src=ALWAYS_NOT_BRANCH.
- ADD x0,x1,x2 → reg_wren=0. BNE offset −8 → imm=0xFFFFFFF8.
- MUL x3,x1,x2 (0x022081B3) → op=MUL with DECODE_RV32M_EN defined; illegal=1 without it.
